// File: rtl/pmem_arbiter_if.sv
// Signal bundle between the two cache controllers, the arbiter and the memory port.
// The arbiter uses the slave view; the caches and the memory side together use the master view.
interface pmem_arbiter_if #(
    parameter int unsigned s_line = 256,
    parameter int unsigned s_addr = 32
);
    logic              i_pmem_read;
    logic [s_addr-1:0] i_pmem_address;
    logic [s_line-1:0] i_pmem_rdata;
    logic              i_pmem_resp;

    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [s_addr-1:0] d_pmem_address;
    logic [s_line-1:0] d_pmem_wdata;
    logic [s_line-1:0] d_pmem_rdata;
    logic              d_pmem_resp;

    logic              mem_read;
    logic              mem_write;
    logic [s_addr-1:0] mem_address;
    logic [s_line-1:0] mem_wdata;
    logic [s_line-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_pmem_read, i_pmem_address,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  mem_rdata, mem_resp,
        output i_pmem_rdata, i_pmem_resp,
        output d_pmem_rdata, d_pmem_resp,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_pmem_read, i_pmem_address,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output mem_rdata, mem_resp,
        input  i_pmem_rdata, i_pmem_resp,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// The grant is held until mem_resp; every completion is followed by one IDLE cycle.
module pmem_arbiter #(
    parameter int unsigned s_line = 256,
    parameter int unsigned s_addr = 32
) (
    input logic           clk,
    input logic           rst,
    pmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t state, state_next;
    grant_t last_grant, last_grant_next;
    logic   i_req, d_req;

    assign i_req = bus.i_pmem_read;
    assign d_req = bus.d_pmem_read | bus.d_pmem_write;

    // Line data is a straight pass-through; each cache only looks at it in its resp cycle.
    assign bus.i_pmem_rdata = bus.mem_rdata;
    assign bus.d_pmem_rdata = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Next state and memory command; rst masks everything so an abandoned grant never pulses resp.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = s_addr'(0);
        bus.mem_wdata   = s_line'(0);
        bus.i_pmem_resp = 1'b0;
        bus.d_pmem_resp = 1'b0;

        if (!rst) begin
            case (state)
                IDLE: begin
                    if (i_req && (!d_req || last_grant == GRANT_D)) begin
                        state_next      = SERVE_I;
                        last_grant_next = GRANT_I;
                    end else if (d_req) begin
                        state_next      = SERVE_D;
                        last_grant_next = GRANT_D;
                    end
                end
                SERVE_I: begin
                    bus.mem_read    = 1'b1;
                    bus.mem_address = bus.i_pmem_address;
                    if (bus.mem_resp) begin
                        bus.i_pmem_resp = 1'b1;
                        state_next      = IDLE;
                    end
                end
                SERVE_D: begin
                    // A simultaneous read and write is resolved as write-only.
                    bus.mem_write   = bus.d_pmem_write;
                    bus.mem_read    = bus.d_pmem_read & ~bus.d_pmem_write;
                    bus.mem_address = bus.d_pmem_address;
                    bus.mem_wdata   = bus.d_pmem_wdata;
                    if (bus.mem_resp) begin
                        bus.d_pmem_resp = 1'b1;
                        state_next      = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level grant model and per-cache read-data scoreboards.
`timescale 1ns/1ps
module tb_pmem_arbiter;
    localparam int unsigned S_LINE = 256;
    localparam int unsigned S_ADDR = 32;
    localparam int unsigned CW     = 320;

    typedef logic [S_LINE-1:0] line_t;
    typedef logic [S_ADDR-1:0] addr_t;

    logic clk;
    logic rst;

    pmem_arbiter_if #(.s_line(S_LINE), .s_addr(S_ADDR)) bus ();
    pmem_arbiter #(.s_line(S_LINE), .s_addr(S_ADDR)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total;
    int bad;

    line_t store [addr_t];
    line_t iq[$];
    line_t dq[$];
    int    served[$];
    int    i_resp_cnt, d_resp_cnt;
    int    run_len, last_run_len;

    int owner;
    int last;

    int unsigned lat_min, lat_max, mem_cnt, gap_max;
    bit          stray;
    int          i_left, d_left, i_gap, d_gap, i_seen, d_seen;
    bit          i_busy, d_busy;

    always #5 clk = ~clk;

    function automatic line_t line_at(addr_t a);
        if (store.exists(a)) return store[a];
        return {8{a ^ 32'h5A3C_0F96}};
    endfunction

    function automatic line_t rand_line();
        line_t v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(string name, logic [CW-1:0] act, logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic issue_i(addr_t a);
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = a;
        iq.push_back(line_at(a));
        i_busy = 1'b1;
    endtask

    // kind: 0 read, 1 write, 2 read+write together (must be served as a write)
    task automatic issue_d(addr_t a, int kind, line_t w);
        bus.d_pmem_read    = (kind != 1);
        bus.d_pmem_write   = (kind != 0);
        bus.d_pmem_address = a;
        bus.d_pmem_wdata   = w;
        if (kind == 0) dq.push_back(line_at(a));
        d_busy = 1'b1;
    endtask

    // Requesters drop on the cycle after their resp and optionally reissue.
    task automatic drive_requesters();
        int r;
        if (i_busy && i_resp_cnt != i_seen) begin
            i_seen = i_resp_cnt;
            i_busy = 1'b0;
            bus.i_pmem_read = 1'b0;
            if (i_left > 0) i_left--;
            i_gap = int'($urandom_range(gap_max, 0));
        end
        if (d_busy && d_resp_cnt != d_seen) begin
            d_seen = d_resp_cnt;
            d_busy = 1'b0;
            bus.d_pmem_read  = 1'b0;
            bus.d_pmem_write = 1'b0;
            if (d_left > 0) d_left--;
            d_gap = int'($urandom_range(gap_max, 0));
        end
        if (!i_busy && i_left > 0) begin
            if (i_gap == 0) issue_i(addr_t'(32'h1000 + ($urandom_range(15, 0) << 5)));
            else i_gap--;
        end
        if (!d_busy && d_left > 0) begin
            if (d_gap == 0) begin
                r = int'($urandom_range(7, 0));
                issue_d(addr_t'(32'h2000 + ($urandom_range(15, 0) << 5)),
                        (r == 0) ? 2 : ((r < 4) ? 0 : 1), rand_line());
            end else d_gap--;
        end
    endtask

    // Memory: responds after a random latency; stray forces a resp while no command is up.
    task automatic mem_step();
        if (bus.mem_read || bus.mem_write) begin
            if (mem_cnt == 0) mem_cnt = $urandom_range(lat_max, lat_min);
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.mem_resp = 1'b1;
                if (bus.mem_write) store[bus.mem_address] = bus.mem_wdata;
                bus.mem_rdata = bus.mem_read ? line_at(bus.mem_address) : rand_line();
            end else begin
                bus.mem_resp  = 1'b0;
                bus.mem_rdata = rand_line();
            end
        end else begin
            mem_cnt       = 0;
            bus.mem_resp  = stray;
            bus.mem_rdata = rand_line();
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive_requesters();
        #1;
        mem_step();
    endtask

    task automatic wait_served(int n, int budget);
        int b;
        b = budget;
        while (served.size() < n && b > 0) begin
            cycle();
            b--;
        end
        check("served_count", CW'(served.size()), CW'(n));
    endtask

    // Transaction-level monitor: picks the grant from pending requests and checks every cycle.
    initial begin
        logic              ir, dr;
        logic [S_LINE-1:0] exp_line;
        logic [CW-1:0]     exp_cmd;
        owner = -1;
        last  = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_resp", CW'({bus.i_pmem_resp, bus.d_pmem_resp}), CW'(0));
                owner   = -1;
                last    = 1;
                run_len = 0;
            end else if (owner < 0) begin
                check("idle_out", CW'({bus.mem_read, bus.mem_write, bus.i_pmem_resp, bus.d_pmem_resp,
                                        bus.mem_address, bus.mem_wdata}), CW'(0));
                ir = bus.i_pmem_read;
                dr = bus.d_pmem_read | bus.d_pmem_write;
                if (ir || dr) begin
                    owner   = (ir && dr) ? ((last == 1) ? 0 : 1) : (ir ? 0 : 1);
                    last    = owner;
                    run_len = 0;
                end
            end else begin
                run_len++;
                if (owner == 0)
                    exp_cmd = CW'({1'b1, 1'b0, bus.i_pmem_address, {S_LINE{1'b0}}});
                else
                    exp_cmd = CW'({bus.d_pmem_read & ~bus.d_pmem_write, bus.d_pmem_write,
                                   bus.d_pmem_address, bus.d_pmem_wdata});
                check(owner == 0 ? "cmd_i" : "cmd_d",
                      CW'({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata}), exp_cmd);
                if (bus.mem_resp) begin
                    check("resp_pair", CW'({bus.i_pmem_resp, bus.d_pmem_resp}),
                          CW'((owner == 0) ? 2'b10 : 2'b01));
                    if (owner == 0) begin
                        check("i_queue_nonempty", CW'(iq.size() > 0), CW'(1));
                        if (iq.size() > 0) begin
                            exp_line = iq.pop_front();
                            check("i_rdata", CW'(bus.i_pmem_rdata), CW'(exp_line));
                        end
                        i_resp_cnt++;
                    end else begin
                        if (!bus.d_pmem_write) begin
                            check("d_queue_nonempty", CW'(dq.size() > 0), CW'(1));
                            if (dq.size() > 0) begin
                                exp_line = dq.pop_front();
                                check("d_rdata", CW'(bus.d_pmem_rdata), CW'(exp_line));
                            end
                        end
                        d_resp_cnt++;
                    end
                    served.push_back(owner);
                    last_run_len = run_len;
                    owner = -1;
                end else begin
                    check("no_resp", CW'({bus.i_pmem_resp, bus.d_pmem_resp}), CW'(0));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        bus.i_pmem_read = 1'b0;  bus.i_pmem_address = '0;
        bus.d_pmem_read = 1'b0;  bus.d_pmem_write = 1'b0;
        bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
        bus.mem_resp = 1'b0;     bus.mem_rdata = '0;
        lat_min = 1; lat_max = 1; mem_cnt = 0; gap_max = 0; stray = 1'b0;
        i_left = 0; d_left = 0; i_gap = 0; d_gap = 0; i_seen = 0; d_seen = 0;
        i_busy = 1'b0; d_busy = 1'b0;

        repeat (3) cycle();
        rst = 1'b0;

        // Reset tie: I wins, D follows after one IDLE cycle.
        store[32'h1000] = {32{8'hA5}};
        lat_min = 2; lat_max = 2;
        cycle();
        issue_i(32'h0000_1000);
        issue_d(32'h0000_2000, 0, '0);
        wait_served(2, 40);
        check("tie_first", CW'(served[0]), CW'(0));
        check("tie_second", CW'(served[1]), CW'(1));
        served.delete();

        // Lone D write held for a 10-cycle memory latency, then read back.
        lat_min = 10; lat_max = 10;
        cycle();
        issue_d(32'h0000_3FE0, 1, {8{32'hDEAD_BEEF}});
        wait_served(1, 40);
        check("write_hold_len", CW'(last_run_len), CW'(10));
        lat_min = 1; lat_max = 1;
        issue_d(32'h0000_3FE0, 0, '0);
        wait_served(2, 20);
        served.delete();

        // Round-robin under continuous demand.
        lat_min = 3; lat_max = 3; gap_max = 0;
        i_left = 2; d_left = 2;
        wait_served(4, 100);
        for (int k = 0; k < 4; k++) check("rr_order", CW'(served[k]), CW'(k % 2));
        served.delete();
        cycle();

        // I drops its request mid-transaction; the grant is held to completion.
        lat_min = 6; lat_max = 6;
        issue_i(32'h0000_1040);
        repeat (3) cycle();
        bus.i_pmem_read = 1'b0;
        wait_served(1, 30);
        check("drop_served_i", CW'(served[0]), CW'(0));
        served.delete();
        cycle();

        // Reset while a D write is on the memory port.
        lat_min = 30; lat_max = 30;
        issue_d(32'h0000_2040, 1, rand_line());
        repeat (2) cycle();
        check("pre_rst_write", CW'(bus.mem_write), CW'(1));
        rst = 1'b1;
        bus.d_pmem_write = 1'b0;
        d_busy = 1'b0;
        cycle();
        rst = 1'b0;
        check("rst_abort_cmd", CW'({bus.mem_write, bus.mem_read, bus.d_pmem_resp, bus.i_pmem_resp}), CW'(0));
        lat_min = 2; lat_max = 2;
        issue_i(32'h0000_1060);
        issue_d(32'h0000_2060, 0, '0);
        wait_served(2, 40);
        check("post_rst_tie", CW'(served[0]), CW'(0));
        served.delete();
        cycle();

        // Stray memory response while idle.
        stray = 1'b1;
        cycle();
        check("stray_resp", CW'({bus.i_pmem_resp, bus.d_pmem_resp}), CW'(0));
        stray = 1'b0;
        cycle();
        check("stray_state", CW'({bus.mem_read, bus.mem_write}), CW'(0));

        // Randomized traffic from both caches.
        lat_min = 1; lat_max = 5; gap_max = 3;
        i_left = 30; d_left = 30;
        for (int b = 0; b < 3000 && (i_left > 0 || d_left > 0 || i_busy || d_busy); b++) cycle();
        check("random_drain", CW'({i_busy, d_busy, i_left > 0, d_left > 0}), CW'(0));
        repeat (3) cycle();
        check("queues_empty", CW'(iq.size() + dq.size()), CW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction cache and the data cache.
- Each cache controller issues whole-line pmem reads or writes and waits for its resp pulse.
- The arbiter grants one requester at a time and forwards that requester's command, address and data to memory until the transaction completes.
- Ties are broken round-robin so neither cache starves.
- Sits between the two cache_control/datapath pairs and the cacheline adaptor.

Parameters:
- s_line, 256, cache line width in bits.
- s_addr, 32, address width in bits.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_pmem_read  input  1  I-cache line read request
- i_pmem_address  input  s_addr  I-cache line address
- i_pmem_rdata  output  s_line  line returned to I-cache
- i_pmem_resp  output  1  I-cache transaction complete, one-cycle pulse
- d_pmem_read  input  1  D-cache line read request
- d_pmem_write  input  1  D-cache line write-back request
- d_pmem_address  input  s_addr  D-cache line address
- d_pmem_wdata  input  s_line  D-cache write-back line
- d_pmem_rdata  output  s_line  line returned to D-cache
- d_pmem_resp  output  1  D-cache transaction complete, one-cycle pulse
- mem_read  output  1  read command to memory
- mem_write  output  1  write command to memory
- mem_address  output  s_addr  address to memory
- mem_wdata  output  s_line  write data to memory
- mem_rdata  input  s_line  read data from memory
- mem_resp  input  1  memory transaction complete

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - State goes to IDLE; last_grant goes to D, so I wins the first tie.
  - After reset: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, i_pmem_resp=0, d_pmem_resp=0.
  - rst asserted mid-transaction abandons the grant immediately, with no resp pulse.
- States: IDLE, SERVE_I, SERVE_D. The state register updates on posedge clk.
- IDLE:
  - All mem_* commands are 0. A mem_resp arriving in IDLE is ignored.
  - If only I requests (i_pmem_read): go to SERVE_I.
  - If only D requests (d_pmem_read or d_pmem_write): go to SERVE_D.
  - If both request: grant the one not equal to last_grant. last_grant is updated on entry to SERVE_x.
- SERVE_I:
  - mem_read=1, mem_write=0, mem_address=i_pmem_address; mem_wdata don't-care, driven 0.
  - On mem_resp=1: i_pmem_resp=1 for that cycle, next state is IDLE.
  - Otherwise stay, even if i_pmem_read drops. The grant is held until mem_resp.
- SERVE_D:
  - mem_read=d_pmem_read, mem_write=d_pmem_write, mem_address=d_pmem_address, mem_wdata=d_pmem_wdata.
  - d_pmem_read and d_pmem_write both high is illegal. In that case drive write only (mem_read=0).
  - On mem_resp=1: d_pmem_resp=1 for that cycle, next state is IDLE.
- Command outputs and resp outputs are combinational from state plus inputs; there are no registered data paths.
- i_pmem_rdata=mem_rdata and d_pmem_rdata=mem_rdata, unconditionally. Data is valid only in the requester's resp cycle.
- Latency:
  - A request seen in IDLE at cycle N drives the memory command from cycle N+1.
  - The resp pulse is in the same cycle as mem_resp.
  - One mandatory IDLE cycle follows every completion.
  - Requesters deassert on their resp cycle. A request still high in that IDLE cycle is treated as a new request.
- Never more than one of i_pmem_resp and d_pmem_resp high in a cycle. The non-granted resp is always 0.
- D-cache dirty eviction: the write-back and the subsequent line fill are two separate grants. An I request pending after the write-back wins the tie (round-robin), and the D fill follows.

Test Plan:
- Reset priority tie: reset, then i_pmem_read=1 with i_pmem_address=0x0000_1000 and d_pmem_read=1 with d_pmem_address=0x0000_2000 asserted together.
  - Cycle+1: mem_read=1, mem_address=0x1000.
  - mem_resp with mem_rdata=0xA5..A5: i_pmem_resp=1 and i_pmem_rdata=0xA5..A5, d_pmem_resp=0.
  - D is then served at 0x2000 after one IDLE cycle.
- Lone D write: d_pmem_write=1, d_pmem_address=0x0000_3FE0, d_pmem_wdata=0xDEAD..BEEF.
  - mem_write=1, mem_read=0, mem_wdata matches.
  - Memory delays mem_resp 10 cycles: command held steady all 10 cycles, then d_pmem_resp pulses for exactly 1 cycle.
- Round-robin: both caches request continuously for 4 transactions, each with a 3-cycle memory latency.
  - Grant order is I, D, I, D.
  - No cycle has both resps high.
- Requester drops mid-transaction: grant I, deassert i_pmem_read 2 cycles later.
  - mem_read stays 1 until mem_resp.
  - i_pmem_resp pulses, then state returns to IDLE.
- Reset mid-operation: rst during SERVE_D with mem_write=1.
  - Next cycle: mem_write=0, no resp pulse.
  - A subsequent tie grants I first.
- Stray response: mem_resp=1 while IDLE with no requests.
  - i_pmem_resp=0, d_pmem_resp=0, state remains IDLE.
